// File: rtl/sevenseg_scan.sv
// Multiplexed N-digit seven-segment driver: double-buffered digit codes scanned onto a shared
// active-low segment bus with per-digit anodes, hex/decimal decode and leading-zero blanking.
module sevenseg_scan #(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic                  load,
   input  logic                  hex_en,
   input  logic                  lzs_en,
   output logic [6:0]            seg,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     an,
   output logic                  frame
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PCNT_MAX  = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PCNT_BLNK = PW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
   localparam logic [6:0]    SEG_BLANK = 7'b1111111;

   logic [PW-1:0]          pcnt_q, pcnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [4*DIGITS-1:0]    pv_q, pv_d, dv_q, dv_d;
   logic [DIGITS-1:0]      pdp_q, pdp_d, ddp_q, ddp_d;
   logic                   pvalid_q, pvalid_d;
   logic [6:0]             seg_q, seg_d;
   logic                   dp_out_q, dp_out_d;
   logic [DIGITS-1:0]      an_q, an_d;
   logic                   frame_q, frame_d;

   logic                   pcnt_tc;
   logic                   xfer;
   logic                   active;
   logic [3:0]             dig_w [DIGITS];
   logic [DIGITS:0]        zero_above;
   logic [DIGITS-1:0]      supp_w;
   logic [3:0]             cur_dig;
   logic                   cur_dp;
   logic                   cur_supp;

   function automatic logic [6:0] decode(input logic [3:0] code, input logic hex);
      case (code)
         4'h0:    return 7'b1000000;
         4'h1:    return 7'b1111001;
         4'h2:    return 7'b0100100;
         4'h3:    return 7'b0110000;
         4'h4:    return 7'b0011001;
         4'h5:    return 7'b0010010;
         4'h6:    return 7'b0000010;
         4'h7:    return 7'b1111000;
         4'h8:    return 7'b0000000;
         4'h9:    return 7'b0010000;
         4'hA:    return hex ? 7'b0001000 : SEG_BLANK;
         4'hB:    return hex ? 7'b0000011 : SEG_BLANK;
         4'hC:    return hex ? 7'b1000110 : SEG_BLANK;
         4'hD:    return hex ? 7'b0100001 : SEG_BLANK;
         4'hE:    return hex ? 7'b0000110 : SEG_BLANK;
         default: return hex ? 7'b0001110 : SEG_BLANK;
      endcase
   endfunction

   assign pcnt_tc = (pcnt_q == PCNT_MAX);
   assign xfer    = pcnt_tc && (idx_q == IDX_MAX);
   assign active  = (pcnt_q >= PCNT_BLNK);

   // zero_above[i] is set when digit i and every more-significant digit are zero.
   assign zero_above[DIGITS] = 1'b1;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign dig_w[gi]      = dv_q[4*gi +: 4];
         assign zero_above[gi] = zero_above[gi+1] & (dig_w[gi] == 4'h0);
         assign supp_w[gi]     = lzs_en && (gi != 0) && zero_above[gi];
         assign an_d[gi]       = !(active && (idx_q == IW'(gi)));
      end
   endgenerate

   always_comb begin
      pcnt_d   = pcnt_tc ? '0 : pcnt_q + 1'b1;
      idx_d    = idx_q;
      pv_d     = pv_q;
      pdp_d    = pdp_q;
      pvalid_d = pvalid_q;
      dv_d     = dv_q;
      ddp_d    = ddp_q;
      if (pcnt_tc) begin
         idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end
      if (load) begin
         pv_d     = value;
         pdp_d    = dp;
         pvalid_d = 1'b1;
      end
      // A load coinciding with the transfer bypasses the pending buffer so the newest data wins.
      if (xfer) begin
         if (load) begin
            dv_d  = value;
            ddp_d = dp;
         end else if (pvalid_q) begin
            dv_d  = pv_q;
            ddp_d = pdp_q;
         end
         pvalid_d = 1'b0;
      end
   end

   always_comb begin
      cur_dig  = 4'h0;
      cur_dp   = 1'b0;
      cur_supp = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_dig  = dig_w[i];
            cur_dp   = ddp_q[i];
            cur_supp = supp_w[i];
         end
      end
      seg_d    = SEG_BLANK;
      dp_out_d = 1'b1;
      if (active && !cur_supp) begin
         seg_d    = decode(cur_dig, hex_en);
         dp_out_d = ~cur_dp;
      end
      frame_d = xfer;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q   <= '0;
         idx_q    <= '0;
         pv_q     <= '0;
         pdp_q    <= '0;
         pvalid_q <= 1'b0;
         dv_q     <= '0;
         ddp_q    <= '0;
         seg_q    <= SEG_BLANK;
         dp_out_q <= 1'b1;
         an_q     <= '1;
         frame_q  <= 1'b0;
      end else begin
         pcnt_q   <= pcnt_d;
         idx_q    <= idx_d;
         pv_q     <= pv_d;
         pdp_q    <= pdp_d;
         pvalid_q <= pvalid_d;
         dv_q     <= dv_d;
         ddp_q    <= ddp_d;
         seg_q    <= seg_d;
         dp_out_q <= dp_out_d;
         an_q     <= an_d;
         frame_q  <= frame_d;
      end
   end

   assign seg    = seg_q;
   assign dp_out = dp_out_q;
   assign an     = an_q;
   assign frame  = frame_q;

endmodule
